// File: rtl/ws_line_responder.sv
// ---------------------------------------------------------------------------
// ws_line_responder
//
// Wishbone-classic responder for a 512-bit cache-line memory interface.
// Each transaction is either a whole-line read or a byte-masked line write
// to an on-chip RAM of 2^ADDR_WIDTH lines of 64 bytes. The ack is delayed
// by a programmable LATENCY so the block can stand in for a slower
// external memory controller during bring-up and simulation.
//
// Parameters
//   ADDR_WIDTH : line-index bits (capacity 2^ADDR_WIDTH x 64 bytes).
//                Must be 26 or less so the index fits in ws_addr[31:6].
//   LATENCY    : clocks from request capture to ack assertion (1..15).
//
// Ports
//   clk        : single clock, rising edge.
//   rstn       : synchronous active-low reset.
//   ws_addr    : byte address; line index = ws_addr[ADDR_WIDTH+5:6].
//   ws_din     : write data, byte i on ws_din[8i+7:8i].
//   ws_dm      : byte write enables, 1 = write byte i.
//   ws_cyc     : bus cycle valid; dropping it while waiting aborts.
//   ws_stb     : strobe; a request is ws_cyc & ws_stb in IDLE.
//   ws_we      : 1 = write, 0 = read.
//   ws_dout    : registered read data, held until the next completed read.
//   ws_ack     : one-cycle completion pulse.
//   dbg_state  : FSM state (IDLE=0, WAIT=1, ACK=2).
// ---------------------------------------------------------------------------
module ws_line_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [31:0]  ws_addr,
  input  logic [511:0] ws_din,
  input  logic [63:0]  ws_dm,
  input  logic         ws_cyc,
  input  logic         ws_stb,
  input  logic         ws_we,
  output logic [511:0] ws_dout,
  output logic         ws_ack,
  output logic [2:0]   dbg_state
);

  localparam int         LINES    = 1 << ADDR_WIDTH;
  // Counter counts down to zero; the access happens on the edge where it
  // reads zero, which lands the ack exactly LATENCY edges after capture.
  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ACK  = 3'd2
  } state_e;

  // -------------------------------------------------------------------------
  // State and request registers
  // -------------------------------------------------------------------------
  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    we_q, we_d;
  logic [511:0]            din_q, din_d;
  logic [63:0]             dm_q, dm_d;
  logic [511:0]            dout_q, dout_d;
  logic                    ack_q, ack_d;

  logic                    mem_we;

  // Line storage. Single port: a transaction either reads or writes it,
  // never both in the same cycle.
  logic [511:0]            mem [LINES];

  // Address bits outside the line index are deliberately ignored, so that
  // aliased addresses hit the same line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ws_addr[5:0], ws_addr[31:ADDR_WIDTH+6]};

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    we_d    = we_q;
    din_d   = din_q;
    dm_d    = dm_q;
    dout_d  = dout_q;
    ack_d   = 1'b0;
    mem_we  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (ws_cyc && ws_stb) begin
          // Capture everything now; later bus changes are ignored apart
          // from ws_cyc, which is watched for abort.
          idx_d   = ws_addr[ADDR_WIDTH+5:6];
          we_d    = ws_we;
          din_d   = ws_din;
          dm_d    = ws_dm;
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!ws_cyc) begin
          // Master gave up: drop the request without touching RAM or dout.
          state_d = S_IDLE;
        end else if (cnt_q == 4'd0) begin
          state_d = S_ACK;
          ack_d   = 1'b1;
          if (we_q) begin
            mem_we = 1'b1;
          end else begin
            dout_d = mem[idx_q];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      S_ACK: begin
        // Always spend one cycle back in IDLE, so ack can never be high
        // on two consecutive cycles.
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      din_q   <= '0;
      dm_q    <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      we_q    <= we_d;
      din_q   <= din_d;
      dm_q    <= dm_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
    end
  end

  // -------------------------------------------------------------------------
  // RAM write port
  // -------------------------------------------------------------------------
  // NOTE: the RAM has no reset branch; clearing it would prevent block-RAM
  // mapping, and its contents are meant to survive reset. The write is
  // still qualified by rstn so a reset arriving on the access edge discards
  // the pending write.
  always_ff @(posedge clk) begin
    if (mem_we && rstn) begin
      for (int b = 0; b < 64; b++) begin
        if (dm_q[b]) begin
          mem[idx_q][8*b +: 8] <= din_q[8*b +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (all registered)
  // -------------------------------------------------------------------------
  assign ws_dout   = dout_q;
  assign ws_ack    = ack_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_ws_line_responder.sv
// ---------------------------------------------------------------------------
// tb_ws_line_responder
//
// Directed bench for ws_line_responder. Three instances share the bus data
// lines: LATENCY=4 (main), LATENCY=1 and LATENCY=15. Only the instance
// selected by `sel` sees ws_cyc/ws_stb; its outputs are muxed to the
// *_m signals used by the checks.
// ---------------------------------------------------------------------------
module tb_ws_line_responder;

  logic         clk = 1'b0;
  logic         rstn;
  logic [31:0]  ws_addr;
  logic [511:0] ws_din;
  logic [63:0]  ws_dm;
  logic         cyc, stb, ws_we;
  int           sel;

  logic         cyc_i   [3];
  logic         stb_i   [3];
  logic [511:0] dout_i  [3];
  logic         ack_i   [3];
  logic [2:0]   dbg_i   [3];

  logic [511:0] dout_m;
  logic         ack_m;
  logic [2:0]   dbg_m;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  for (genvar j = 0; j < 3; j++) begin : g_sel
    assign cyc_i[j] = cyc && (sel == j);
    assign stb_i[j] = stb && (sel == j);
  end

  assign dout_m = dout_i[sel];
  assign ack_m  = ack_i[sel];
  assign dbg_m  = dbg_i[sel];

  ws_line_responder #(.ADDR_WIDTH(8), .LATENCY(4)) u_l4 (
    .clk(clk), .rstn(rstn), .ws_addr(ws_addr), .ws_din(ws_din),
    .ws_dm(ws_dm), .ws_cyc(cyc_i[0]), .ws_stb(stb_i[0]), .ws_we(ws_we),
    .ws_dout(dout_i[0]), .ws_ack(ack_i[0]), .dbg_state(dbg_i[0]));

  ws_line_responder #(.ADDR_WIDTH(8), .LATENCY(1)) u_l1 (
    .clk(clk), .rstn(rstn), .ws_addr(ws_addr), .ws_din(ws_din),
    .ws_dm(ws_dm), .ws_cyc(cyc_i[1]), .ws_stb(stb_i[1]), .ws_we(ws_we),
    .ws_dout(dout_i[1]), .ws_ack(ack_i[1]), .dbg_state(dbg_i[1]));

  ws_line_responder #(.ADDR_WIDTH(8), .LATENCY(15)) u_l15 (
    .clk(clk), .rstn(rstn), .ws_addr(ws_addr), .ws_din(ws_din),
    .ws_dm(ws_dm), .ws_cyc(cyc_i[2]), .ws_stb(stb_i[2]), .ws_we(ws_we),
    .ws_dout(dout_i[2]), .ws_ack(ack_i[2]), .dbg_state(dbg_i[2]));

  task automatic check(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One transaction on the selected instance. Starts and ends #1 after an
  // edge with the DUT in IDLE. After capture, stb/din/dm/addr are scrambled
  // to show they no longer matter.
  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [511:0] din, input logic [63:0] dm,
                     input int exp_lat, input string tag,
                     output logic [511:0] rd);
    int lat;
    lat     = -1;
    ws_we   = we;
    ws_addr = addr;
    ws_din  = din;
    ws_dm   = dm;
    cyc     = 1'b1;
    stb     = 1'b1;
    @(posedge clk); #1;
    check({tag, " dbg_wait"}, 512'(dbg_m), 512'(3'd1));
    stb     = 1'b0;
    ws_din  = ~din;
    ws_dm   = ~dm;
    ws_addr = addr ^ 32'h0000_03c0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ack_m) begin
        lat = k;
        break;
      end
    end
    check({tag, " latency"}, 512'(lat), 512'(exp_lat));
    check({tag, " dbg_ack"}, 512'(dbg_m), 512'(3'd2));
    rd  = dout_m;
    cyc = 1'b0;
    @(posedge clk); #1;
    check({tag, " ack_pulse"}, 512'(ack_m), 512'(1'b0));
    check({tag, " dbg_idle"}, 512'(dbg_m), 512'(3'd0));
  endtask

  logic [511:0] pat, part_exp, rd, junk, d1, d2;
  int           n_ack, a1, a2;
  logic         seen;

  initial begin
    for (int i = 0; i < 64; i++) pat[8*i +: 8] = 8'(i);
    part_exp = {{60{8'hFF}}, {4{8'h00}}};

    sel = 0; rstn = 1'b0; cyc = 1'b0; stb = 1'b0; ws_we = 1'b0;
    ws_addr = '0; ws_din = '0; ws_dm = '0;

    // Reset state on all three instances.
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset ack", 512'(ack_m), 512'(1'b0));
      check("reset dout", dout_m, '0);
      check("reset dbg", 512'(dbg_m), 512'(3'd0));
    end
    sel  = 0;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Full-line write then read.
    txn(1'b1, 32'h0000_0040, pat, '1, 4, "full_wr", junk);
    txn(1'b0, 32'h0000_0040, '0, '0, 4, "full_rd", rd);
    check("full_rd data", rd, pat);

    // Partial mask on line 2; the writes must not disturb dout.
    txn(1'b1, 32'h0000_0080, {64{8'hFF}}, '1, 4, "part_wr1", junk);
    check("wr keeps dout", dout_m, pat);
    txn(1'b1, 32'h0000_0080, '0, 64'h0000_0000_0000_000F, 4, "part_wr2", junk);
    txn(1'b0, 32'h0000_0080, '0, '0, 4, "part_rd", rd);
    check("part_rd data", rd, part_exp);

    // Write with an empty mask completes but changes nothing.
    txn(1'b1, 32'h0000_0080, '0, '0, 4, "dm0_wr", junk);
    txn(1'b0, 32'h0000_0080, '0, '0, 4, "dm0_rd", rd);
    check("dm0_rd data", rd, part_exp);

    // Abort: seed line 5, then start a write and drop cyc 2 clocks later.
    txn(1'b1, 32'h0000_0140, {64{8'h5A}}, '1, 4, "abort_seed", junk);
    ws_we = 1'b1; ws_addr = 32'h0000_0140; ws_din = {64{8'h11}};
    ws_dm = '1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cyc  = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (ack_m) seen = 1'b1;
    end
    check("abort no_ack", 512'(seen), 512'(1'b0));
    check("abort dbg", 512'(dbg_m), 512'(3'd0));
    check("abort keeps dout", dout_m, part_exp);
    txn(1'b0, 32'h0000_0140, '0, '0, 4, "abort_rd", rd);
    check("abort_rd data", rd, {64{8'h5A}});

    // Back-to-back aliased reads with stb held high throughout.
    ws_we = 1'b0; ws_addr = 32'h0000_0080; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    ws_addr = 32'h0040_0080;
    n_ack = 0; a1 = -1; a2 = -1; d1 = '0; d2 = '0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      if (ack_m) begin
        n_ack++;
        if (n_ack == 1) begin
          a1 = k; d1 = dout_m;
        end else begin
          a2 = k; d2 = dout_m; cyc = 1'b0; stb = 1'b0;
        end
      end
    end
    check("b2b ack_count", 512'(n_ack), 512'(2));
    check("b2b first_ack", 512'(a1), 512'(4));
    check("b2b second_ack", 512'(a2), 512'(10));
    check("b2b dout1", d1, part_exp);
    check("b2b dout2", d2, part_exp);

    // Reset during WAIT of a write to line 7.
    txn(1'b1, 32'h0000_01C0, {64{8'h77}}, '1, 4, "rst_seed", junk);
    ws_we = 1'b1; ws_addr = 32'h0000_01C0; ws_din = '0;
    ws_dm = '1; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst dbg", 512'(dbg_m), 512'(3'd1));
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst ack", 512'(ack_m), 512'(1'b0));
    check("rst dout", dout_m, '0);
    check("rst dbg", 512'(dbg_m), 512'(3'd0));
    rstn = 1'b1; cyc = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack_m) seen = 1'b1;
    end
    check("rst no_ack", 512'(seen), 512'(1'b0));
    txn(1'b0, 32'h0000_01C0, '0, '0, 4, "rst_rd", rd);
    check("rst_rd data", rd, {64{8'h77}});

    // Latency sweep: LATENCY=1 and LATENCY=15 instances.
    sel = 1;
    #1;
    txn(1'b1, 32'h0000_00C0, pat, '1, 1, "l1_wr", junk);
    txn(1'b0, 32'h0000_00C0, '0, '0, 1, "l1_rd", rd);
    check("l1_rd data", rd, pat);
    sel = 2;
    #1;
    txn(1'b1, 32'h0000_00C0, ~pat, '1, 15, "l15_wr", junk);
    txn(1'b0, 32'h0000_00C0, '0, '0, 15, "l15_rd", rd);
    check("l15_rd data", rd, ~pat);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/ws_line_responder.md
Name: ws_line_responder

Overview:
- Wishbone-classic responder for the 512-bit cache-line memory interface driven by the CPU/cache complex (addr/din/dm/cyc/stb/we in, dout/ack out).
- Backs the interface with on-chip block RAM and a programmable response latency.
- Used as a drop-in substitute for the DDR3 wrapper during bring-up and simulation.
- Serves one whole-line read or byte-masked line write per transaction.

Parameters:
- ADDR_WIDTH, 8, number of line-index bits; capacity is 2^ADDR_WIDTH lines of 64 bytes (default 16 KB).
- LATENCY, 4, clocks from the request-capture edge to ack assertion; legal range 1..15.

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rstn, input, 1, reset; synchronous, active-low.
- ws_addr, input, 32, byte address; line index = ws_addr[ADDR_WIDTH+5:6]; bits [5:0] and bits above the index are ignored.
- ws_din, input, 512, write data; byte i = ws_din[8i+7:8i].
- ws_dm, input, 64, byte write enables; 1 = write byte i.
- ws_cyc, input, 1, bus cycle valid.
- ws_stb, input, 1, strobe.
- ws_we, input, 1, 1 = write, 0 = read.
- ws_dout, output, 512, read data (registered).
- ws_ack, output, 1, one-cycle transaction completion pulse.
- dbg_state, output, 3, FSM state: IDLE=0, WAIT=1, ACK=2.

Behaviour:
- Reset (rstn low at an edge):
  - state IDLE, ws_ack=0, ws_dout=0, dbg_state=0, counter=0.
  - RAM contents are not cleared.
- IDLE:
  - When ws_cyc & ws_stb are sampled high: capture line index, ws_we, ws_din and ws_dm into request registers.
  - Load counter with LATENCY-1 and go to WAIT.
- WAIT:
  - If ws_cyc is sampled low: abort. Go to IDLE; no RAM write, no ack, ws_dout unchanged.
  - Else if counter==0: perform the access and go to ACK.
    - Write: RAM bytes with dm=1 take din; bytes with dm=0 keep their old value.
    - Read: ws_dout <= RAM line.
  - Else: counter decrements.
- ACK:
  - ws_ack=1 for exactly this one cycle; go to IDLE.
  - ws_ack is never high for two consecutive cycles.
- Latency:
  - Capture edge at T0; ack is high during the cycle beginning at edge T0+LATENCY.
  - The master samples ack at edge T0+LATENCY+1.
- Inputs only matter at capture: ws_stb/ws_din/ws_dm/ws_addr changes after the capture edge have no effect, except that ws_cyc is monitored for abort.
- Back-to-back requests:
  - A request held high in the IDLE cycle after ACK is a new transaction, captured at that edge.
  - Minimum issue interval is LATENCY+2 clocks.
- Read data:
  - ws_dout is valid in the ack cycle.
  - It holds until the next completed read; writes and aborts do not alter it.
- Write with ws_dm=0: completes and acks normally; RAM is unchanged.
- Address aliasing: addresses differing only in ignored bits map to the same line.
- Reset mid-transaction: immediate return to IDLE; a pending write is discarded and no ack is issued.
- The RAM has a single port; reads and writes never overlap, so there is no read-during-write hazard.

Test Plan:
- Full-line write, then read:
  - Write addr 0x0000_0040, dm=all ones, din = byte i holds i.
  - Read the same address.
  - Required: ack exactly 4 clocks after each capture edge; dout byte i == i.
- Partial mask:
  - Write line 2 with all 0xFF; then write 0x00 with dm=0x0000_0000_0000_000F; read line 2.
  - Required: bytes 0-3 == 0x00; bytes 4-63 == 0xFF.
- Abort:
  - Issue a write to line 5 and drop ws_cyc 2 clocks after capture.
  - Required: no ack; dbg_state returns to 0; a subsequent read of line 5 returns its prior contents.
- Latency sweep:
  - LATENCY=1 and LATENCY=15.
  - Required: ack exactly 1 and 15 clocks after capture respectively; single-cycle pulse; dbg_state sequence 0 -> 1 -> 2 -> 0.
- Back-to-back and aliasing:
  - Hold ws_stb high across two reads, to 0x0000_0080 then 0x0040_0080 (ADDR_WIDTH=8).
  - Required: two acks LATENCY+2 clocks apart; identical dout for both reads.
- Reset mid-write:
  - Assert rstn low during WAIT of a write to line 7.
  - Required: next edge gives ack=0, dout=0, dbg_state=0; line 7 is unchanged on readback.
